// File: rtl/opb_reg_pkg.sv
// Shared constants and FSM encoding for the OPB register slave.
// Offsets are word offsets within the 64-byte register window.
package opb_reg_pkg;

  localparam int          RW_COUNT     = 6;
  localparam logic [3:0]  OFF_STATUS   = 4'd6;
  localparam logic [3:0]  OFF_COUNTER  = 4'd7;
  localparam int          WINDOW_BYTES = 64;
  localparam int          ADDR_LSB     = $clog2(WINDOW_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_ERR  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Merge new data into an old word, one byte lane per enable bit.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/opb_reg_slave.sv
// OPB register slave: six RW registers, a status word and a free-running
// cycle counter in a 64-byte window, with single-cycle registered acks.
module opb_reg_slave
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0001_0000,
  parameter logic [31:0] C_RST_VAL  = 32'h0
) (
  input  logic         opb_clk,
  input  logic         opb_rst,
  input  logic         opb_select,
  input  logic         opb_rnw,
  input  logic [31:0]  opb_abus,
  input  logic [3:0]   opb_be,
  input  logic [31:0]  opb_dbus,
  output logic [31:0]  sl_dbus,
  output logic         sl_xferack,
  output logic         sl_errack,
  output logic         sl_retry,
  output logic         sl_toutsup,
  output logic [191:0] reg_out,
  input  logic [31:0]  user_status
);

  state_t      r_state;
  logic [31:0] r_regs [RW_COUNT];
  logic [31:0] r_cnt;
  logic [31:0] r_dbus;
  logic        r_xferack;
  logic        r_errack;

  logic        w_hit;
  logic [3:0]  w_off;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_hit    = opb_select && (opb_abus[31:ADDR_LSB] == C_BASEADDR[31:ADDR_LSB]);
  assign w_off    = opb_abus[5:2];
  assign w_unused = ^opb_abus[1:0];

  always_comb begin
    w_rdata = 32'h0;
    for (int k = 0; k < RW_COUNT; k++) begin
      if (w_off == 4'(k)) w_rdata = r_regs[k];
    end
    if (w_off == OFF_STATUS)  w_rdata = user_status;
    if (w_off == OFF_COUNTER) w_rdata = r_cnt;
  end

  // Only IDLE looks at the bus, so a select held through the ack is never
  // acknowledged twice; HOLD waits for the master to drop select.
  always_ff @(posedge opb_clk) begin
    if (opb_rst) begin
      r_state   <= ST_IDLE;
      r_xferack <= 1'b0;
      r_errack  <= 1'b0;
      r_dbus    <= 32'h0;
      r_cnt     <= 32'h0;
      for (int k = 0; k < RW_COUNT; k++) r_regs[k] <= C_RST_VAL;
    end else begin
      r_cnt     <= r_cnt + 32'd1;
      r_xferack <= 1'b0;
      r_errack  <= 1'b0;
      r_dbus    <= 32'h0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            if (w_off <= OFF_COUNTER) begin
              r_state   <= ST_ACK;
              r_xferack <= 1'b1;
              if (opb_rnw) begin
                r_dbus <= w_rdata;
              end else begin
                for (int k = 0; k < RW_COUNT; k++) begin
                  if (w_off == 4'(k)) r_regs[k] <= apply_be(r_regs[k], opb_dbus, opb_be);
                end
              end
            end else begin
              r_state  <= ST_ERR;
              r_errack <= 1'b1;
            end
          end
        end
        ST_ACK:  r_state <= ST_HOLD;
        ST_ERR:  r_state <= ST_HOLD;
        ST_HOLD: if (!opb_select) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sl_dbus    = r_dbus;
  assign sl_xferack = r_xferack;
  assign sl_errack  = r_errack;
  assign sl_retry   = 1'b0;
  assign sl_toutsup = 1'b0;

  for (genvar g = 0; g < RW_COUNT; g++) begin : g_regout
    assign reg_out[32*g +: 32] = r_regs[g];
  end

endmodule

// File: tb/tb_opb_reg_slave.sv
// Self-checking bench for opb_reg_slave: scoreboard of expected responses,
// one task per feature, called in sequence.
module tb_opb_reg_slave;

  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam logic [31:0] RSTVAL = 32'hA5A5_0F0F;
  localparam logic [31:0] STATUS = 32'hCAFE_1234;

  logic         opb_clk = 1'b0;
  logic         opb_rst;
  logic         opb_select;
  logic         opb_rnw;
  logic [31:0]  opb_abus;
  logic [3:0]   opb_be;
  logic [31:0]  opb_dbus;
  logic [31:0]  sl_dbus;
  logic         sl_xferack;
  logic         sl_errack;
  logic         sl_retry;
  logic         sl_toutsup;
  logic [191:0] reg_out;
  logic [31:0]  user_status;

  typedef struct {
    logic         ack;
    logic         err;
    logic [31:0]  data;
    logic [191:0] regs;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] mdl [6];
  int          nChecks = 0;
  int          nErrors = 0;

  opb_reg_slave #(.C_BASEADDR(BASE), .C_RST_VAL(RSTVAL)) dut (
    .opb_clk(opb_clk), .opb_rst(opb_rst), .opb_select(opb_select),
    .opb_rnw(opb_rnw), .opb_abus(opb_abus), .opb_be(opb_be),
    .opb_dbus(opb_dbus), .sl_dbus(sl_dbus), .sl_xferack(sl_xferack),
    .sl_errack(sl_errack), .sl_retry(sl_retry), .sl_toutsup(sl_toutsup),
    .reg_out(reg_out), .user_status(user_status)
  );

  always #5 opb_clk = ~opb_clk;

  function automatic logic [191:0] packModel();
    return {mdl[5], mdl[4], mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  function automatic logic [31:0] laneMerge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  // Model update plus scoreboard push for one access, done as it is driven.
  task automatic expectAccess(input logic rnw, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] data);
    exp_t e;
    int   off;
    off = int'(addr[5:2]);
    e.ack = (off <= 7);
    e.err = (off >= 8);
    e.data = 32'h0;
    if (rnw && off < 6) e.data = mdl[off];
    if (rnw && off == 6) e.data = STATUS;
    if (!rnw && off < 6) mdl[off] = laneMerge(mdl[off], data, be);
    e.regs = packModel();
    sbQ.push_back(e);
  endtask

  // Drives one access and reports what came back; checking is done by callers.
  task automatic applyStimulus(input logic rnw, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] data,
                               output logic gotX, output logic gotE,
                               output logic [31:0] gotD, output logic [191:0] gotRegs,
                               output logic both, output logic afterAck,
                               output logic [31:0] afterD);
    gotX = 1'b0; gotE = 1'b0; gotD = 32'h0; gotRegs = '0; both = 1'b0;
    @(negedge opb_clk);
    opb_select = 1'b1; opb_rnw = rnw; opb_abus = addr; opb_be = be; opb_dbus = data;
    for (int i = 0; i < 20; i++) begin
      @(posedge opb_clk); #1;
      if (sl_xferack && sl_errack) both = 1'b1;
      if (sl_xferack || sl_errack) begin
        gotX = sl_xferack; gotE = sl_errack; gotD = sl_dbus; gotRegs = reg_out;
        break;
      end
    end
    opb_select = 1'b0;
    @(posedge opb_clk); #1;
    afterAck = sl_xferack | sl_errack;
    afterD   = sl_dbus;
    @(posedge opb_clk);
  endtask

  task automatic test_reset();
    opb_rst = 1'b1; opb_select = 1'b0; opb_rnw = 1'b0; opb_abus = '0;
    opb_be = '0; opb_dbus = '0; user_status = STATUS;
    for (int k = 0; k < 6; k++) mdl[k] = RSTVAL;
    repeat (3) @(posedge opb_clk);
    #1;
    nChecks++;
    if ({sl_xferack, sl_errack, sl_retry, sl_toutsup} !== 4'b0) begin
      nErrors++; $display("[TB] FAIL reset_acks got=%b want=0000", {sl_xferack, sl_errack, sl_retry, sl_toutsup});
    end
    nChecks++;
    if (sl_dbus !== 32'h0) begin
      nErrors++; $display("[TB] FAIL reset_dbus got=%h want=0", sl_dbus);
    end
    nChecks++;
    if (reg_out !== packModel()) begin
      nErrors++; $display("[TB] FAIL reset_regs got=%h want=%h", reg_out, packModel());
    end
    @(negedge opb_clk);
    opb_rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic gx, ge, bo, aa; logic [31:0] gd, ad; logic [191:0] gr; exp_t e;
    expectAccess(1'b0, BASE + 32'h08, 4'hF, 32'hDEADBEEF);
    applyStimulus(1'b0, BASE + 32'h08, 4'hF, 32'hDEADBEEF, gx, ge, gd, gr, bo, aa, ad);
    e = sbQ.pop_front();
    nChecks++;
    if ({gx, ge, bo} !== {e.ack, e.err, 1'b0}) begin
      nErrors++; $display("[TB] FAIL wr_ack got=%b want=%b", {gx, ge, bo}, {e.ack, e.err, 1'b0});
    end
    nChecks++;
    if (gr[95:64] !== 32'hDEADBEEF || gr !== e.regs) begin
      nErrors++; $display("[TB] FAIL wr_regs got=%h want=%h", gr, e.regs);
    end
    nChecks++;
    if (aa !== 1'b0) begin
      nErrors++; $display("[TB] FAIL wr_pulse got=%b want=0", aa);
    end
    expectAccess(1'b1, BASE + 32'h08, 4'hF, 32'h0);
    applyStimulus(1'b1, BASE + 32'h08, 4'hF, 32'h0, gx, ge, gd, gr, bo, aa, ad);
    e = sbQ.pop_front();
    nChecks++;
    if (gx !== 1'b1 || gd !== e.data) begin
      nErrors++; $display("[TB] FAIL rd_data got=%b/%h want=1/%h", gx, gd, e.data);
    end
    nChecks++;
    if (aa !== 1'b0 || ad !== 32'h0) begin
      nErrors++; $display("[TB] FAIL rd_after got=%b/%h want=0/0", aa, ad);
    end
  endtask

  task automatic test_byte_lanes();
    logic gx, ge, bo, aa; logic [31:0] gd, ad; logic [191:0] gr; exp_t e;
    logic [31:0] addrs [3]; logic [3:0] bes [3]; logic [31:0] datas [3];
    addrs = '{BASE, BASE, BASE + 32'h14};
    bes   = '{4'hF, 4'b0101, 4'b0000};
    datas = '{32'h0, 32'h11223344, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      expectAccess(1'b0, addrs[i], bes[i], datas[i]);
      applyStimulus(1'b0, addrs[i], bes[i], datas[i], gx, ge, gd, gr, bo, aa, ad);
      e = sbQ.pop_front();
      nChecks++;
      if (gx !== 1'b1 || ge !== 1'b0 || gr !== e.regs) begin
        nErrors++; $display("[TB] FAIL lane_%0d got=%b%b/%h want=10/%h", i, gx, ge, gr, e.regs);
      end
    end
    nChecks++;
    if (reg_out[31:0] !== 32'h0022_0044) begin
      nErrors++; $display("[TB] FAIL lane_reg0 got=%h want=00220044", reg_out[31:0]);
    end
  endtask

  task automatic test_readonly();
    logic gx, ge, bo, aa; logic [31:0] gd, ad; logic [191:0] gr; exp_t e;
    for (int i = 6; i < 8; i++) begin
      expectAccess(1'b0, BASE + 32'(4 * i), 4'hF, 32'h5555_AAAA);
      applyStimulus(1'b0, BASE + 32'(4 * i), 4'hF, 32'h5555_AAAA, gx, ge, gd, gr, bo, aa, ad);
      e = sbQ.pop_front();
      nChecks++;
      if (gx !== 1'b1 || gr !== e.regs) begin
        nErrors++; $display("[TB] FAIL ro_write_%0d got=%b/%h want=1/%h", i, gx, gr, e.regs);
      end
    end
    expectAccess(1'b1, BASE + 32'h18, 4'hF, 32'h0);
    applyStimulus(1'b1, BASE + 32'h18, 4'hF, 32'h0, gx, ge, gd, gr, bo, aa, ad);
    e = sbQ.pop_front();
    nChecks++;
    if (gx !== 1'b1 || gd !== e.data) begin
      nErrors++; $display("[TB] FAIL status_read got=%b/%h want=1/%h", gx, gd, e.data);
    end
  endtask

  task automatic test_invalid_and_miss();
    logic gx, ge, bo, aa; logic [31:0] gd, ad; logic [191:0] gr; exp_t e;
    expectAccess(1'b1, BASE + 32'h20, 4'hF, 32'h0);
    applyStimulus(1'b1, BASE + 32'h20, 4'hF, 32'h0, gx, ge, gd, gr, bo, aa, ad);
    e = sbQ.pop_front();
    nChecks++;
    if ({gx, ge, bo} !== {e.ack, e.err, 1'b0} || gd !== 32'h0 || aa !== 1'b0) begin
      nErrors++; $display("[TB] FAIL invalid_rd got=%b%b%b/%h/%b want=010/0/0", gx, ge, bo, gd, aa);
    end
    expectAccess(1'b0, BASE + 32'h3C, 4'hF, 32'h1234_5678);
    applyStimulus(1'b0, BASE + 32'h3C, 4'hF, 32'h1234_5678, gx, ge, gd, gr, bo, aa, ad);
    e = sbQ.pop_front();
    nChecks++;
    if (ge !== 1'b1 || gx !== 1'b0 || reg_out !== e.regs) begin
      nErrors++; $display("[TB] FAIL invalid_wr got=%b%b/%h want=01/%h", gx, ge, reg_out, e.regs);
    end
    applyStimulus(1'b0, BASE + 32'h40, 4'hF, 32'h9999_9999, gx, ge, gd, gr, bo, aa, ad);
    nChecks++;
    if ({gx, ge, aa} !== 3'b000 || reg_out !== packModel()) begin
      nErrors++; $display("[TB] FAIL miss got=%b%b%b/%h want=000/%h", gx, ge, aa, reg_out, packModel());
    end
  endtask

  task automatic test_held_select();
    exp_t e; int nAck; logic [31:0] gd; logic seen;
    expectAccess(1'b1, BASE + 32'h08, 4'hF, 32'h0);
    @(negedge opb_clk);
    opb_select = 1'b1; opb_rnw = 1'b1; opb_abus = BASE + 32'h08; opb_be = 4'hF;
    nAck = 0; gd = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge opb_clk); #1;
      if (sl_xferack) begin nAck++; gd = sl_dbus; end
    end
    e = sbQ.pop_front();
    nChecks++;
    if (nAck != 1 || gd !== e.data) begin
      nErrors++; $display("[TB] FAIL held_once got=%0d/%h want=1/%h", nAck, gd, e.data);
    end
    expectAccess(1'b1, BASE + 32'h08, 4'hF, 32'h0);
    @(negedge opb_clk); opb_select = 1'b0;
    @(negedge opb_clk); opb_select = 1'b1;
    seen = 1'b0; gd = 32'h0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(posedge opb_clk); #1;
      if (sl_xferack) begin seen = 1'b1; gd = sl_dbus; end
    end
    e = sbQ.pop_front();
    nChecks++;
    if (seen !== 1'b1 || gd !== e.data) begin
      nErrors++; $display("[TB] FAIL held_second got=%b/%h want=1/%h", seen, gd, e.data);
    end
    opb_select = 1'b0;
    repeat (2) @(posedge opb_clk);
  endtask

  task automatic test_reset_mid();
    logic gx, ge, bo, aa; logic [31:0] gd, ad; logic [191:0] gr;
    @(negedge opb_clk);
    opb_select = 1'b1; opb_rnw = 1'b0; opb_abus = BASE + 32'h04;
    opb_be = 4'hF; opb_dbus = 32'h1234_5678; opb_rst = 1'b1;
    @(posedge opb_clk); #1;
    for (int k = 0; k < 6; k++) mdl[k] = RSTVAL;
    nChecks++;
    if (sl_xferack !== 1'b0 || sl_errack !== 1'b0) begin
      nErrors++; $display("[TB] FAIL rstmid_ack got=%b%b want=00", sl_xferack, sl_errack);
    end
    @(negedge opb_clk);
    opb_select = 1'b0; opb_rst = 1'b0;
    @(posedge opb_clk); #1;
    nChecks++;
    if (sl_xferack !== 1'b0 || reg_out[63:32] !== RSTVAL || reg_out !== packModel()) begin
      nErrors++; $display("[TB] FAIL rstmid_reg1 got=%b/%h want=0/%h", sl_xferack, reg_out[63:32], RSTVAL);
    end
    repeat (2) @(posedge opb_clk);
    applyStimulus(1'b1, BASE + 32'h1C, 4'hF, 32'h0, gx, ge, gd, gr, bo, aa, ad);
    nChecks++;
    if (gx !== 1'b1 || gd < 32'd2 || gd > 32'd4) begin
      nErrors++; $display("[TB] FAIL rstmid_counter got=%b/%0d want=1/3+-1", gx, gd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_readonly();
    test_invalid_and_miss();
    test_held_select();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
